// File: rtl/vlg_gray_pkg.sv
// Shared helpers for the Gray counter: binary<->Gray conversion and prescaler sizing.
package vlg_gray_pkg;
  localparam int MAX_W = 32;

  function automatic int presc_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  function automatic logic [MAX_W-1:0] bin2gray(input logic [MAX_W-1:0] b);
    return b ^ (b >> 1);
  endfunction

  // Prefix XOR from the MSB down; zero upper bits leave narrow values untouched.
  function automatic logic [MAX_W-1:0] gray2bin(input logic [MAX_W-1:0] g);
    logic [MAX_W-1:0] b;
    b[MAX_W-1] = g[MAX_W-1];
    for (int i = MAX_W-2; i >= 0; i--) b[i] = b[i+1] ^ g[i];
    return b;
  endfunction
endpackage

// File: rtl/vlg_gray_counter_if.sv
// Control/status bundle of the Gray counter; master drives controls, slave is the counter.
interface vlg_gray_counter_if #(parameter int WIDTH = 4);
  logic             i_en;
  logic             i_dir;
  logic             i_load;
  logic [WIDTH-1:0] i_load_gray;
  logic [WIDTH-1:0] o_gray;
  logic [WIDTH-1:0] o_bin;
  logic             o_tick;
  logic             o_wrap;
  logic             o_err;

  modport master (output i_en, i_dir, i_load, i_load_gray,
                  input  o_gray, o_bin, o_tick, o_wrap, o_err);
  modport slave  (input  i_en, i_dir, i_load, i_load_gray,
                  output o_gray, o_bin, o_tick, o_wrap, o_err);
endinterface

// File: rtl/vlg_tick_gen.sv
// Prescaler: counts 0..PRESCALE_CNT-1 while enabled and strobes o_tick on the last count.
module vlg_tick_gen import vlg_gray_pkg::*; #(
  parameter int PRESCALE_CNT = 200_000_000
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_en,
  input  logic i_clr,
  output logic o_tick
);
  localparam int            CW   = presc_w(PRESCALE_CNT);
  localparam logic [CW-1:0] LAST = CW'(PRESCALE_CNT - 1);

  logic [CW-1:0] cnt;
  logic          last;

  assign last = (cnt == LAST);

  always_ff @(posedge i_clk or posedge i_rst)
    if (i_rst)       cnt <= '0;
    else if (i_clr)  cnt <= '0;
    else if (i_en)   cnt <= last ? '0 : cnt + CW'(1);

  // A clear (load) swallows a step due in the same cycle.
  assign o_tick = i_en & last & ~i_clr;
endmodule

// File: rtl/vlg_gray_counter.sv
// Up/down Gray counter with prescaled stepping, synchronous load and wrap pulse.
// Define VLG_GRAY_CHECK_EN to build the sticky one-bit-change checker driving o_err.
module vlg_gray_counter import vlg_gray_pkg::*; #(
  parameter int WIDTH        = 4,
  parameter int PRESCALE_CNT = 200_000_000
) (
  input logic               i_clk,
  input logic               i_rst,
  vlg_gray_counter_if.slave bus
);
  logic             step;
  logic [WIDTH-1:0] bin_q, gray_q, next_bin;
  logic             tick_q, wrap_q, wrap_due;

  vlg_tick_gen #(.PRESCALE_CNT(PRESCALE_CNT)) u_tick (
    .i_clk  (i_clk),
    .i_rst  (i_rst),
    .i_en   (bus.i_en),
    .i_clr  (bus.i_load),
    .o_tick (step)
  );

  assign next_bin = bus.i_dir ? bin_q + WIDTH'(1) : bin_q - WIDTH'(1);
  assign wrap_due = bus.i_dir ? (&bin_q) : ~(|bin_q);

  // Binary and Gray update on the same edge so they never disagree.
  always_ff @(posedge i_clk or posedge i_rst)
    if (i_rst) begin
      bin_q  <= '0;
      gray_q <= '0;
      tick_q <= 1'b0;
      wrap_q <= 1'b0;
    end else begin
      tick_q <= 1'b0;
      wrap_q <= 1'b0;
      if (bus.i_load) begin
        gray_q <= bus.i_load_gray;
        bin_q  <= WIDTH'(gray2bin(MAX_W'(bus.i_load_gray)));
      end else if (step) begin
        bin_q  <= next_bin;
        gray_q <= WIDTH'(bin2gray(MAX_W'(next_bin)));
        tick_q <= 1'b1;
        wrap_q <= wrap_due;
      end
    end

  assign bus.o_gray = gray_q;
  assign bus.o_bin  = bin_q;
  assign bus.o_tick = tick_q;
  assign bus.o_wrap = wrap_q;

`ifdef VLG_GRAY_CHECK_EN
  logic [WIDTH-1:0] prev_gray;
  logic             load_q, err_q, bad_step;

  // Any change not caused by a load, and every step, must flip exactly one bit.
  assign bad_step = ~load_q & (tick_q | (gray_q != prev_gray)) &
                    ($countones(gray_q ^ prev_gray) != 1);

  always_ff @(posedge i_clk or posedge i_rst)
    if (i_rst) begin
      prev_gray <= '0;
      load_q    <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      prev_gray <= gray_q;
      load_q    <= bus.i_load;
      if (bad_step) err_q <= 1'b1;
    end

  assign bus.o_err = err_q;
`else
  assign bus.o_err = 1'b0;
`endif
endmodule

// File: tb/tb_vlg_gray_counter.sv
// Directed bench for vlg_gray_counter (WIDTH=4, PRESCALE_CNT=4 plus a PRESCALE_CNT=1 copy).
module tb_vlg_gray_counter;
  localparam int W = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  vlg_gray_counter_if #(.WIDTH(W)) bus ();
  vlg_gray_counter_if #(.WIDTH(W)) bus1 ();

  vlg_gray_counter #(.WIDTH(W), .PRESCALE_CNT(4)) u_dut  (.i_clk(clk), .i_rst(rst), .bus(bus));
  vlg_gray_counter #(.WIDTH(W), .PRESCALE_CNT(1)) u_dut1 (.i_clk(clk), .i_rst(rst), .bus(bus1));

  typedef struct packed {
    logic [W-1:0] gray;
    logic [W-1:0] bin;
    logic         tick;
    logic         wrap;
    logic         err;
    logic [W-1:0] g1;
    logic         t1;
  } exp_t;

  exp_t         q[$];
  int           vectors = 0;
  int           miscompares = 0;
  int           m_cnt = 0;
  logic [W-1:0] m_bin = '0;
  logic [W-1:0] m1_bin = '0;
  logic         m_err = 1'b0;
  logic [W-1:0] fv;
  logic [W-1:0] seq [16] = '{4'h1, 4'h3, 4'h2, 4'h6, 4'h7, 4'h5, 4'h4, 4'hC,
                             4'hD, 4'hF, 4'hE, 4'hA, 4'hB, 4'h9, 4'h8, 4'h0};

  function automatic logic [W-1:0] b2g(input logic [W-1:0] b);
    return b ^ (b >> 1);
  endfunction

  function automatic logic [W-1:0] g2b(input logic [W-1:0] g);
    logic [W-1:0] b;
    b[W-1] = g[W-1];
    for (int i = W-2; i >= 0; i--) b[i] = b[i+1] ^ g[i];
    return b;
  endfunction

  task automatic chkv(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chkb(input string tag, input logic obs, input logic exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0b expected=%0b", tag, obs, exp);
    end
  endtask

  // One clock: predict from current inputs, queue, then pop and compare after the edge.
  task automatic cyc();
    exp_t e;
    e = '0;
    if (rst) begin
      m_cnt = 0; m_bin = '0; m1_bin = '0; m_err = 1'b0;
    end else begin
      if (bus.i_load) begin
        m_bin = g2b(bus.i_load_gray);
        m_cnt = 0;
      end else if (bus.i_en) begin
        if (m_cnt == 3) begin
          e.tick = 1'b1;
          e.wrap = bus.i_dir ? (m_bin == '1) : (m_bin == '0);
          m_bin  = bus.i_dir ? m_bin + W'(1) : m_bin - W'(1);
          m_cnt  = 0;
        end else m_cnt++;
      end
      if (bus1.i_en) begin
        m1_bin = m1_bin + W'(1);
        e.t1   = 1'b1;
      end
    end
    e.bin = m_bin; e.gray = b2g(m_bin); e.g1 = b2g(m1_bin); e.err = m_err;
    q.push_back(e);
    @(posedge clk); #1;
    e = q.pop_front();
    chkv("gray", bus.o_gray, e.gray);
    chkv("bin", bus.o_bin, e.bin);
    chkb("tick", bus.o_tick, e.tick);
    chkb("wrap", bus.o_wrap, e.wrap);
    chkb("err", bus.o_err, e.err);
    chkv("p1_gray", bus1.o_gray, e.g1);
    chkb("p1_tick", bus1.o_tick, e.t1);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end

  initial begin
    bus.i_en = 1'b0; bus.i_dir = 1'b1; bus.i_load = 1'b0; bus.i_load_gray = '0;
    bus1.i_en = 1'b0; bus1.i_dir = 1'b1; bus1.i_load = 1'b0; bus1.i_load_gray = '0;

    // reset state
    repeat (2) @(posedge clk);
    #1;
    chkv("rst_gray", bus.o_gray, 4'h0);
    chkv("rst_bin", bus.o_bin, 4'h0);
    chkb("rst_tick", bus.o_tick, 1'b0);
    chkb("rst_wrap", bus.o_wrap, 1'b0);
    chkb("rst_err", bus.o_err, 1'b0);
    chkv("rst_p1_gray", bus1.o_gray, 4'h0);

    // 1: count up, tick every 4th cycle, wrap only on 8->0
    rst = 1'b0; bus.i_en = 1'b1; bus.i_dir = 1'b1; bus1.i_en = 1'b1;
    for (int i = 0; i < 64; i++) begin
      cyc();
      chkb("t1_tick", bus.o_tick, (i % 4) == 3);
      chkb("t1_wrap", bus.o_wrap, i == 63);
      if ((i % 4) == 3) chkv("t1_seq", bus.o_gray, seq[i / 4]);
    end

    // 2: count down from 0
    bus.i_dir = 1'b0;
    for (int i = 0; i < 8; i++) begin
      cyc();
      if (i == 3) begin
        chkv("t2_gray8", bus.o_gray, 4'h8);
        chkv("t2_binF", bus.o_bin, 4'hF);
        chkb("t2_wrap", bus.o_wrap, 1'b1);
      end
      if (i == 7) begin
        chkv("t2_gray9", bus.o_gray, 4'h9);
        chkv("t2_binE", bus.o_bin, 4'hE);
        chkb("t2_nowrap", bus.o_wrap, 1'b0);
      end
    end

    // 3: load in a tick-due cycle
    repeat (3) cyc();
    bus.i_load = 1'b1; bus.i_load_gray = 4'hA;
    cyc();
    chkv("t3_gray", bus.o_gray, 4'hA);
    chkv("t3_bin", bus.o_bin, 4'hC);
    chkb("t3_tick", bus.o_tick, 1'b0);
    bus.i_load = 1'b0;
    for (int i = 0; i < 4; i++) begin
      cyc();
      chkb("t3_next_tick", bus.o_tick, i == 3);
    end

    // 4: freeze mid-period, direction changed between ticks
    repeat (2) cyc();
    bus.i_dir = 1'b1;
    bus.i_en  = 1'b0;
    for (int i = 0; i < 10; i++) begin
      cyc();
      chkv("t4_hold_gray", bus.o_gray, 4'hE);
      chkb("t4_hold_tick", bus.o_tick, 1'b0);
    end
    bus.i_en = 1'b1;
    cyc();
    chkb("t4_resume_notick", bus.o_tick, 1'b0);
    cyc();
    chkb("t4_resume_tick", bus.o_tick, 1'b1);
    chkv("t4_gray", bus.o_gray, 4'hA);

`ifdef VLG_GRAY_CHECK_EN
    // 6: checker quiet on legal steps, sticky on a forced two-bit jump
    for (int i = 0; i < 80; i++) begin
      bus.i_dir = ((i / 12) % 2) == 0;
      cyc();
    end
    chkb("t6_err_clean", bus.o_err, 1'b0);
    bus.i_en = 1'b0;
    fv = b2g(m_bin) ^ 4'h3;
    force u_dut.gray_q = fv;
    @(posedge clk); #1;
    release u_dut.gray_q;
    m_err = 1'b1;
    chkb("t6_err_set", bus.o_err, 1'b1);
    bus.i_load = 1'b1; bus.i_load_gray = 4'h0;
    cyc();
    bus.i_load = 1'b0; bus.i_en = 1'b1;
    repeat (8) cyc();
    chkb("t6_err_sticky", bus.o_err, 1'b1);
`endif

    // 5: asynchronous reset between edges, then a full prescale period
    bus.i_load = 1'b1; bus.i_load_gray = 4'h7; bus.i_dir = 1'b1;
    cyc();
    bus.i_load = 1'b0;
    repeat (2) cyc();
    #2 rst = 1'b1;
    #1;
    chkv("t5_async_gray", bus.o_gray, 4'h0);
    chkv("t5_async_bin", bus.o_bin, 4'h0);
    chkv("t5_async_p1", bus1.o_gray, 4'h0);
    chkb("t5_async_err", bus.o_err, 1'b0);
    cyc();
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      cyc();
      chkb("t5_restart_tick", bus.o_tick, i == 3);
    end
    chkv("t5_restart_gray", bus.o_gray, 4'h1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
